// File: rtl/ps2_scancode_decoder_if.sv
// Signal bundle between the PS/2 receiver FIFO, the scancode decoder and its consumers.
// master drives the byte stream (receiver side); slave is the decoder.
interface ps2_scancode_decoder_if #(
    parameter int COUNT_W = 8
);
    logic [7:0]         ps2_data;
    logic               ps2_ready;
    logic               ps2_overflow;
    logic               nextdata_n;
    logic [7:0]         key_code;
    logic               key_ext;
    logic               key_down;
    logic [7:0]         ascii;
    logic               make_pulse;
    logic               break_pulse;
    logic [COUNT_W-1:0] press_count;
    logic               ovf_err;

    modport master (
        output ps2_data,
        output ps2_ready,
        output ps2_overflow,
        input  nextdata_n,
        input  key_code,
        input  key_ext,
        input  key_down,
        input  ascii,
        input  make_pulse,
        input  break_pulse,
        input  press_count,
        input  ovf_err
    );

    modport slave (
        input  ps2_data,
        input  ps2_ready,
        input  ps2_overflow,
        output nextdata_n,
        output key_code,
        output key_ext,
        output key_down,
        output ascii,
        output make_pulse,
        output break_pulse,
        output press_count,
        output ovf_err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: pops bytes via a WAIT/POP/GAP handshake and tracks make/break state.
// Define PS2_ASCII_EN to build the a-z / 0-9 ASCII lookup; otherwise ascii is tied to 0.
module ps2_scancode_decoder #(
    parameter int COUNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    ps2_scancode_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   capture;
    logic   nextdata_n_q;

    logic [7:0]         byte_p0;
    logic               vld_p0;

    logic [7:0]         key_code_p1, key_code_d;
    logic               key_ext_p1, key_ext_d;
    logic               key_down_p1, key_down_d;
    logic               make_p1, make_d;
    logic               break_p1, break_d;
    logic [COUNT_W-1:0] press_count_p1, press_count_d;
    logic               brk_pend, brk_pend_d;
    logic               ext_pend, ext_pend_d;
    logic               ovf_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WAIT;
            nextdata_n_q <= 1'b1;
            vld_p0       <= 1'b0;
        end else begin
            state        <= state_next;
            nextdata_n_q <= (state_next != POP);
            vld_p0       <= capture;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            WAIT: begin
                if (bus.ps2_ready) begin
                    capture    = 1'b1;
                    state_next = POP;
                end
            end
            POP:     state_next = GAP;
            GAP:     state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Stage p0: head byte captured on leaving WAIT, valid during POP
    always_ff @(posedge clk) begin
        if (capture) begin
            byte_p0 <= bus.ps2_data;
        end
    end

    // Stage p1: decode of the captured byte into key state and strobes
    always_comb begin
        key_code_d    = key_code_p1;
        key_ext_d     = key_ext_p1;
        key_down_d    = key_down_p1;
        press_count_d = press_count_p1;
        make_d        = 1'b0;
        break_d       = 1'b0;
        brk_pend_d    = brk_pend;
        ext_pend_d    = ext_pend;
        if (vld_p0) begin
            if (byte_p0 == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (byte_p0 == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (brk_pend) begin
                break_d    = 1'b1;
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
                if (byte_p0 == key_code_p1) begin
                    key_down_d = 1'b0;
                end
            end else if (key_down_p1 && (byte_p0 == key_code_p1)) begin
                // typematic repeat of the held key
                ext_pend_d = 1'b0;
            end else begin
                key_code_d    = byte_p0;
                key_ext_d     = ext_pend;
                key_down_d    = 1'b1;
                make_d        = 1'b1;
                press_count_d = press_count_p1 + COUNT_W'(1);
                ext_pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_p1    <= 8'h00;
            key_ext_p1     <= 1'b0;
            key_down_p1    <= 1'b0;
            make_p1        <= 1'b0;
            break_p1       <= 1'b0;
            press_count_p1 <= '0;
            brk_pend       <= 1'b0;
            ext_pend       <= 1'b0;
            ovf_err_q      <= 1'b0;
        end else begin
            key_code_p1    <= key_code_d;
            key_ext_p1     <= key_ext_d;
            key_down_p1    <= key_down_d;
            make_p1        <= make_d;
            break_p1       <= break_d;
            press_count_p1 <= press_count_d;
            brk_pend       <= brk_pend_d;
            ext_pend       <= ext_pend_d;
            ovf_err_q      <= ovf_err_q | bus.ps2_overflow;
        end
    end

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Extended (E0) codes share set-2 values with letters, so they never map.
    assign bus.ascii = key_ext_p1 ? 8'h00 : set2_to_ascii(key_code_p1);
`else
    assign bus.ascii = 8'h00;
`endif

    assign bus.nextdata_n  = nextdata_n_q;
    assign bus.key_code    = key_code_p1;
    assign bus.key_ext     = key_ext_p1;
    assign bus.key_down    = key_down_p1;
    assign bus.make_pulse  = make_p1;
    assign bus.break_pulse = break_p1;
    assign bus.press_count = press_count_p1;
    assign bus.ovf_err     = ovf_err_q;
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, which sets the width of press_count.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_data, input, 8, FIFO head byte from the PS/2 receiver; valid while ps2_ready=1.
REQ-005 SHALL have port ps2_ready, input, 1, receiver FIFO non-empty.
REQ-006 SHALL have port ps2_overflow, input, 1, receiver FIFO overflow flag.
REQ-007 SHALL have port nextdata_n, output, 1, active-low pop strobe to the receiver.
REQ-008 SHALL have port key_code, output, 8, scancode of the most recently made key.
REQ-009 SHALL have port key_ext, output, 1, the most recent make was E0-prefixed.
REQ-010 SHALL have port key_down, output, 1, key_code is currently held.
REQ-011 SHALL have port ascii, output, 8, ASCII of key_code; 0 if unmapped.
REQ-012 SHALL have port make_pulse, output, 1, one-cycle strobe on a new key press.
REQ-013 SHALL have port break_pulse, output, 1, one-cycle strobe on a key release.
REQ-014 SHALL have port press_count, output, COUNT_W, number of new presses.
REQ-015 SHALL have port ovf_err, output, 1, sticky flag set when the receiver FIFO overflows.

Function
REQ-016 SHALL use a handshake FSM with states WAIT, POP, GAP; nextdata_n is registered, and is 0 only in POP.
REQ-017 In WAIT with ps2_ready=1, SHALL capture ps2_data and go to POP; with ps2_ready=0, SHALL stay in WAIT.
REQ-018 POP SHALL last exactly one cycle and then go to GAP.
REQ-019 GAP SHALL last one cycle, ignore ps2_ready, and then go to WAIT; maximum throughput is one byte per 3 cycles.
REQ-020 The captured byte SHALL be decoded in the cycle after capture; outputs and pulses are registered.
REQ-021 Byte 0xF0 SHALL set break_pending; no output changes.
REQ-022 Byte 0xE0 SHALL set ext_pending; no output changes.
REQ-023 A byte other than 0xF0/0xE0 with break_pending=1 SHALL be a release; if the code equals key_code, key_down<=0.
REQ-024 A release SHALL pulse break_pulse for 1 cycle and clear both pending flags.
REQ-025 A byte other than 0xF0/0xE0 with break_pending=0 and key_down=1 and code==key_code SHALL be a typematic repeat.
REQ-026 A typematic repeat SHALL produce no make_pulse and no count change, and SHALL clear ext_pending.
REQ-027 Any other make byte SHALL load key_code<=byte, key_ext<=ext_pending and key_down<=1.
REQ-028 Such a make SHALL pulse make_pulse for 1 cycle, increment press_count (wrapping max->0), and clear ext_pending.
REQ-029 A release whose code differs from key_code SHALL still pulse break_pulse and SHALL leave key_down unchanged.
REQ-030 ps2_overflow sampled 1 SHALL set ovf_err, which stays set until reset; decoding continues.
REQ-031 0xF0 followed by 0xE0 SHALL set both pending flags; the release is then reported on the next byte.

Reset
REQ-032 rst=0 SHALL asynchronously force WAIT, nextdata_n=1, key_code=0, key_ext=0, key_down=0, make_pulse=0, break_pulse=0, press_count=0, ovf_err=0, and clear both pending flags.
REQ-033 Reset asserted during POP SHALL abort the pop; after release, the FSM restarts in WAIT with no partial-sequence state retained.

Configuration
REQ-034 With PS2_ASCII_EN defined, ascii SHALL be a lookup of key_code covering set-2 letters a-z (lowercase) and digits 0-9; all other codes give 0; ascii=0 when key_ext=1.
REQ-035 Without PS2_ASCII_EN, ascii SHALL be constant 0 and no lookup logic is instantiated.

Verification
REQ-036 FIFO bytes 1C, F0, 1C -> make_pulse once, key_code=1C, ascii=61 (ASCII_EN), then break_pulse, key_down=0, press_count=1.
REQ-037 Bytes 1B, 1B, 1B, F0, 1B -> one make_pulse, press_count=1, key_down=1 until the final byte.
REQ-038 Bytes E0, 75, E0, F0, 75 -> key_code=75, key_ext=1, ascii=0, then break_pulse, key_down=0.
REQ-039 ps2_ready held 1 for 9 bytes -> nextdata_n low exactly 9 times, each low for 1 cycle, spaced 3 cycles apart.
REQ-040 256 distinct make/break pairs with COUNT_W=8 -> press_count wraps to 0; a ps2_overflow pulse sets ovf_err, and it stays set.
REQ-041 rst asserted during POP after byte 1C -> all outputs are at reset values, nextdata_n=1, and the next 1C produces a fresh make.
